// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: opcodes, strobe encodings, FSM state and instruction decode helpers
package mips_mc_pkg;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_LUI = 4'd7;
  localparam logic [1:0] NPC_PC4 = 2'b00, NPC_BR = 2'b01, NPC_J = 2'b10, NPC_JR = 2'b11;
  localparam logic [1:0] EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_UPPER = 2'b10;
  localparam logic [1:0] REG_RT = 2'b00, REG_RD = 2'b01, REG_R31 = 2'b10;
  localparam logic [1:0] WD_ALU = 2'b00, WD_DR = 2'b01, WD_PC = 2'b10;
  localparam logic [1:0] ERR_NONE = 2'b00, ERR_ILL = 2'b01, ERR_IMEM = 2'b10, ERR_DMEM = 2'b11;
  typedef enum logic [2:0] {S_IF, S_DE, S_EX, S_MEM, S_WB, S_ERR} state_t;
  typedef enum logic [3:0] {C_ILL, C_RALU, C_IALU, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR} cls_t;
  function automatic cls_t decode(input logic [5:0] op, input logic [5:0] func);
    case (op)
      OP_R: case (func)
        F_ADDU, F_SUBU, F_AND, F_OR, F_SLT, F_SLL, F_SRL: return C_RALU;
        F_JR: return C_JR;
        default: return C_ILL;
      endcase
      OP_ADDIU, OP_ORI, OP_LUI: return C_IALU;
      OP_LW: return C_LW;
      OP_SW: return C_SW;
      OP_BEQ: return C_BEQ;
      OP_J: return C_J;
      OP_JAL: return C_JAL;
      default: return C_ILL;
    endcase
  endfunction
  function automatic logic [3:0] alu_sel(input logic [5:0] op, input logic [5:0] func);
    case (op)
      OP_R: case (func)
        F_SUBU: return ALU_SUB;
        F_AND: return ALU_AND;
        F_OR: return ALU_OR;
        F_SLT: return ALU_SLT;
        F_SLL: return ALU_SLL;
        F_SRL: return ALU_SRL;
        default: return ALU_ADD;
      endcase
      OP_ORI: return ALU_OR;
      OP_LUI: return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/mips_mc_ctrl_hs_if.sv
// mips_mc_ctrl_hs_if: instruction/data memory req-ack handshake (master=controller, slave=memory)
interface mips_mc_ctrl_hs_if;
  logic imem_req, imem_ack, dmem_req, dmem_ack, DMWr;
  modport master(output imem_req, dmem_req, DMWr, input imem_ack, dmem_ack);
  modport slave(input imem_req, dmem_req, DMWr, output imem_ack, dmem_ack);
endinterface

// File: rtl/mc_wdog.sv
// mc_wdog: wait-cycle watchdog; i_clr resets, i_en counts, o_exp flags the TIMEOUT-th wait cycle
module mc_wdog #(
  parameter int TIMEOUT = 255,
  parameter int TO_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_exp
);
  localparam logic [TO_W-1:0] LIM = TO_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  logic [TO_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  end
  assign o_exp = i_en && (TIMEOUT != 0) && (r_cnt == LIM);
endmodule

// File: rtl/mips_mc_ctrl_hs.sv
// mips_mc_ctrl_hs: multicycle MIPS controller with req/ack memories, watchdog, halt state and perf counters
module mips_mc_ctrl_hs
  import mips_mc_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  mips_mc_ctrl_hs_if.master mem,
  input  logic [5:0]       Op,
  input  logic [5:0]       Func,
  input  logic             Zero,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RFWr,
  output logic             BSel,
  output logic [3:0]       ALUOp,
  output logic [1:0]       NPCOp,
  output logic [1:0]       ExtSel,
  output logic [1:0]       RegSel,
  output logic [1:0]       WDSel,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instret
);
  state_t r_st, w_nx;
  cls_t w_cls;
  logic w_wait, w_ack, w_exp;
  logic [1:0] r_err;
  assign w_cls = decode(Op, Func);
  assign w_wait = (r_st == S_IF) || (r_st == S_MEM);
  assign w_ack = (r_st == S_IF) ? mem.imem_ack : mem.dmem_ack;
  mc_wdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_wdog (
    .clk(clk), .rst(rst), .i_clr(!w_wait || w_ack), .i_en(w_wait), .o_exp(w_exp)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= S_IF;
      r_err <= ERR_NONE;
      cyc_cnt <= '0;
      instret <= '0;
    end else begin
      r_st <= w_nx;
      if (w_nx == S_ERR && r_st != S_ERR)
        r_err <= (r_st == S_DE) ? ERR_ILL : (r_st == S_IF) ? ERR_IMEM : ERR_DMEM;
      if (r_st != S_ERR) cyc_cnt <= cyc_cnt + 1'b1;
      if (r_st != S_IF && w_nx == S_IF) instret <= instret + 1'b1;
    end
  end
  always_comb begin
    w_nx = r_st;
    case (r_st)
      S_IF: w_nx = mem.imem_ack ? S_DE : w_exp ? S_ERR : S_IF;
      S_DE: w_nx = (w_cls == C_ILL) ? S_ERR : (w_cls == C_J || w_cls == C_JAL) ? S_IF : S_EX;
      S_EX: w_nx = (w_cls == C_LW || w_cls == C_SW) ? S_MEM : (w_cls == C_BEQ || w_cls == C_JR) ? S_IF : S_WB;
      S_MEM: w_nx = mem.dmem_ack ? ((w_cls == C_SW) ? S_IF : S_WB) : w_exp ? S_ERR : S_MEM;
      S_WB: w_nx = S_IF;
      S_ERR: w_nx = S_ERR;
      default: w_nx = S_IF;
    endcase
  end
  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.DMWr = 1'b0;
    PCWr = 1'b0;
    IRWr = 1'b0;
    RFWr = 1'b0;
    BSel = 1'b0;
    ALUOp = ALU_ADD;
    NPCOp = NPC_PC4;
    ExtSel = EXT_ZERO;
    RegSel = REG_RT;
    WDSel = WD_ALU;
    if (!rst) begin
      case (r_st)
        S_IF: begin
          mem.imem_req = 1'b1;
          IRWr = mem.imem_ack;
          PCWr = mem.imem_ack;
        end
        S_DE: begin
          PCWr = (w_cls == C_J) || (w_cls == C_JAL);
          NPCOp = PCWr ? NPC_J : NPC_PC4;
          RFWr = (w_cls == C_JAL);
          RegSel = RFWr ? REG_R31 : REG_RT;
          WDSel = RFWr ? WD_PC : WD_ALU;
        end
        S_EX: begin
          ALUOp = (w_cls == C_BEQ) ? ALU_SUB : (w_cls == C_LW || w_cls == C_SW) ? ALU_ADD : alu_sel(Op, Func);
          BSel = (w_cls == C_IALU) || (w_cls == C_LW) || (w_cls == C_SW);
          ExtSel = (w_cls == C_IALU) ? ((Op == OP_ORI) ? EXT_ZERO : (Op == OP_LUI) ? EXT_UPPER : EXT_SIGN)
                 : BSel ? EXT_SIGN : EXT_ZERO;
          PCWr = (w_cls == C_JR) || (w_cls == C_BEQ && Zero);
          NPCOp = (w_cls == C_JR) ? NPC_JR : (w_cls == C_BEQ) ? NPC_BR : NPC_PC4;
        end
        S_MEM: begin
          mem.dmem_req = 1'b1;
          mem.DMWr = (w_cls == C_SW);
        end
        S_WB: begin
          RFWr = 1'b1;
          RegSel = (w_cls == C_RALU) ? REG_RD : REG_RT;
          WDSel = (w_cls == C_LW) ? WD_DR : WD_ALU;
        end
        default: ;
      endcase
    end
  end
  assign halted = (r_st == S_ERR);
  assign err_code = r_err;
endmodule

// File: tb/tb_mips_mc_ctrl_hs.sv
// tb_mips_mc_ctrl_hs: directed per-cycle expectations queued by stimulus, checked by a negedge monitor
module tb_mips_mc_ctrl_hs;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0;
  logic [5:0] op = 6'h00, func = 6'h00;
  logic pcwr, irwr, rfwr, bsel, halted;
  logic [3:0] aluop;
  logic [1:0] npcop, extsel, regsel, wdsel, err_code;
  logic [31:0] cyc_cnt, instret;
  mips_mc_ctrl_hs_if mem_if();
  mips_mc_ctrl_hs #(.TIMEOUT(4), .TO_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem(mem_if), .Op(op), .Func(func), .Zero(zero),
    .PCWr(pcwr), .IRWr(irwr), .RFWr(rfwr), .BSel(bsel), .ALUOp(aluop), .NPCOp(npcop),
    .ExtSel(extsel), .RegSel(regsel), .WDSel(wdsel), .halted(halted), .err_code(err_code),
    .cyc_cnt(cyc_cnt), .instret(instret)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic ireq, dreq, dmwr, pcwr, irwr, rfwr, bsel;
    logic [3:0] alu;
    logic [1:0] npc, ext, regs, wds;
  } stb_t;
  typedef struct packed {
    stb_t s;
    logic halt;
    logic [1:0] err;
    logic [31:0] cyc, ins;
  } rec_t;
  rec_t q[$];
  int checks = 0, fails = 0, ncyc = 0;
  logic e_halt = 1'b0;
  logic [1:0] e_err = 2'b00;
  logic [31:0] e_cyc = 0, e_ins = 0;
  stb_t act;
  assign act = {mem_if.imem_req, mem_if.dmem_req, mem_if.DMWr, pcwr, irwr, rfwr, bsel,
                aluop, npcop, extsel, regsel, wdsel};
  always @(negedge clk) begin
    rec_t r;
    if (q.size() != 0) begin
      r = q.pop_front();
      ncyc++;
      checks++;
      if (act !== r.s) begin
        fails++;
        $display("FAIL strobes cycle %0d: got %h want %h", ncyc, act, r.s);
      end
      checks++;
      if ({halted, err_code, cyc_cnt, instret} !== {r.halt, r.err, r.cyc, r.ins}) begin
        fails++;
        $display("FAIL status cycle %0d: got halt=%b err=%b cyc=%0d ins=%0d want halt=%b err=%b cyc=%0d ins=%0d",
                 ncyc, halted, err_code, cyc_cnt, instret, r.halt, r.err, r.cyc, r.ins);
      end
    end
  end
  task automatic step(input stb_t s, input bit fin = 1'b0, input bit rs = 1'b0, input logic [1:0] to_err = 2'b00);
    rec_t r;
    rst = rs;
    r.s = s;
    r.halt = e_halt;
    r.err = e_err;
    r.cyc = e_cyc;
    r.ins = e_ins;
    q.push_back(r);
    @(posedge clk);
    #1;
    if (rs) begin
      e_halt = 1'b0;
      e_err = 2'b00;
      e_cyc = 0;
      e_ins = 0;
    end else begin
      if (!e_halt) e_cyc++;
      if (fin) e_ins++;
      if (to_err != 2'b00) begin
        e_halt = 1'b1;
        e_err = to_err;
      end
    end
  endtask
  task automatic c_if(input bit ack, input logic [1:0] to_err = 2'b00);
    stb_t s = '0;
    mem_if.imem_ack = ack;
    s.ireq = 1'b1;
    s.irwr = ack;
    s.pcwr = ack;
    step(s, 1'b0, 1'b0, to_err);
  endtask
  task automatic run_alu(input logic [5:0] o, input logic [5:0] f, input bit imm, input logic [3:0] alu, input logic [1:0] ext);
    stb_t s = '0;
    op = o;
    func = f;
    c_if(1'b1);
    step('0);
    s.alu = alu;
    s.bsel = imm;
    s.ext = ext;
    step(s);
    s = '0;
    s.rfwr = 1'b1;
    s.regs = imm ? 2'b00 : 2'b01;
    step(s, 1'b1);
  endtask
  task automatic run_mem(input bit wr, input int waits, input bit fail);
    stb_t s = '0;
    op = wr ? 6'h2B : 6'h23;
    c_if(1'b1);
    step('0);
    s.bsel = 1'b1;
    s.ext = 2'b01;
    step(s);
    s = '0;
    s.dreq = 1'b1;
    s.dmwr = wr;
    mem_if.dmem_ack = 1'b0;
    for (int i = 0; i < waits; i++) step(s, 1'b0, 1'b0, (fail && i == waits - 1) ? 2'b11 : 2'b00);
    if (fail) return;
    mem_if.dmem_ack = 1'b1;
    step(s, wr);
    mem_if.dmem_ack = 1'b0;
    if (wr) return;
    s = '0;
    s.rfwr = 1'b1;
    s.wds = 2'b01;
    step(s, 1'b1);
  endtask
  task automatic run_beq(input bit z);
    stb_t s = '0;
    op = 6'h04;
    zero = z;
    c_if(1'b1);
    step('0);
    s.alu = 4'd1;
    s.npc = 2'b01;
    s.pcwr = z;
    step(s, 1'b1);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    stb_t s;
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    step('0, 1'b0, 1'b1);
    run_alu(6'h00, 6'h21, 1'b0, 4'd0, 2'b00);
    run_alu(6'h00, 6'h23, 1'b0, 4'd1, 2'b00);
    run_alu(6'h00, 6'h24, 1'b0, 4'd2, 2'b00);
    run_alu(6'h00, 6'h25, 1'b0, 4'd3, 2'b00);
    run_alu(6'h00, 6'h2A, 1'b0, 4'd4, 2'b00);
    run_alu(6'h00, 6'h00, 1'b0, 4'd5, 2'b00);
    run_alu(6'h00, 6'h02, 1'b0, 4'd6, 2'b00);
    run_alu(6'h09, 6'h15, 1'b1, 4'd0, 2'b01);
    run_alu(6'h0D, 6'h3F, 1'b1, 4'd3, 2'b00);
    run_alu(6'h0F, 6'h08, 1'b1, 4'd7, 2'b10);
    run_mem(1'b0, 3, 1'b0);
    run_mem(1'b1, 0, 1'b0);
    mem_if.dmem_ack = 1'b1;
    run_beq(1'b1);
    run_beq(1'b0);
    mem_if.dmem_ack = 1'b0;
    op = 6'h02;
    c_if(1'b1);
    s = '0; s.pcwr = 1'b1; s.npc = 2'b10;
    step(s, 1'b1);
    op = 6'h03;
    c_if(1'b1);
    s.rfwr = 1'b1; s.regs = 2'b10; s.wds = 2'b10;
    step(s, 1'b1);
    op = 6'h00; func = 6'h08;
    c_if(1'b1);
    step('0);
    s = '0; s.pcwr = 1'b1; s.npc = 2'b11;
    step(s, 1'b1);
    op = 6'h02;
    for (int i = 0; i < 3; i++) c_if(1'b0);
    c_if(1'b1);
    s = '0; s.pcwr = 1'b1; s.npc = 2'b10;
    step(s, 1'b1);
    step('0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) c_if(1'b0);
    c_if(1'b0, 2'b10);
    mem_if.imem_ack = 1'b1;
    step('0);
    step('0);
    step('0, 1'b0, 1'b1);
    op = 6'h3F;
    c_if(1'b1);
    step('0, 1'b0, 1'b0, 2'b01);
    step('0);
    step('0, 1'b0, 1'b1);
    c_if(1'b0);
    op = 6'h2B;
    c_if(1'b1);
    step('0);
    s = '0; s.bsel = 1'b1; s.ext = 2'b01;
    step(s);
    s = '0; s.dreq = 1'b1; s.dmwr = 1'b1;
    step(s);
    step(s);
    step('0, 1'b0, 1'b1);
    c_if(1'b0);
    run_mem(1'b0, 4, 1'b1);
    step('0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/mips_mc_ctrl_hs.md
# mips_mc_ctrl_hs

Multicycle MIPS control unit for variable-latency memories. It replaces the fixed-timing controller in the multicycle core. Instruction and data memory accesses use req/ack handshakes, and a parametrised watchdog catches stalled accesses. The block adds an illegal-opcode and bus-error halt state and performance counters. It drives the same datapath strobes (PC, IR, RF, ALU, NPC, EXT, write-data muxes) as the fixed-timing controller.

## Interface
Parameters:
- TIMEOUT, 255: maximum wait cycles per memory access; 0 disables the watchdog.
- TO_W, 8: watchdog counter width; requires TIMEOUT < 2^TO_W.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- Op  in  6  ins[31:26] from the IR.
- Func  in  6  ins[5:0] from the IR.
- Zero  in  1  ALU zero flag.
- imem_ack  in  1  instruction memory data valid.
- dmem_ack  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- DMWr  out  1  data write; only ever asserted together with dmem_req.
- PCWr, IRWr, RFWr, BSel  out  1 each  datapath strobes and selects.
- ALUOp  out  4  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 SRL, 7 LUI.
- NPCOp  out  2  next-PC source: 00 PC+4, 01 branch, 10 jump, 11 jr.
- ExtSel  out  2  immediate extension: 00 zero, 01 sign, 10 upper.
- RegSel  out  2  write register: 00 rt, 01 rd, 10 r31.
- WDSel  out  2  write data: 00 ALUOut, 01 DR, 10 PC.
- halted  out  1  set when the block enters ERR.
- err_code  out  2  halt reason: 00 none, 01 illegal instruction, 10 imem timeout, 11 dmem timeout.
- cyc_cnt  out  CNT_W  cycle counter.
- instret  out  CNT_W  retired-instruction counter.

## Operation
- States: IF, DE, EX, MEM, WB, ERR.
- Supported instructions: addu, subu, and, or, slt, sll, srl, jr, addiu, ori, lui, lw, sw, beq, j, jal.
- IF:
  - imem_req=1 for the whole state.
  - On the cycle imem_ack=1: IRWr=1, PCWr=1 with NPCOp=00, then go to DE.
- DE:
  - A/B registers load.
  - An undecodable Op/Func goes to ERR with err_code=01.
  - j: PCWr=1, NPCOp=10, then IF.
  - jal: as j, plus RFWr=1, RegSel=10, WDSel=10. The PC register already holds PC+4 here.
  - All other instructions go to EX.
- EX:
  - R-type and I-type ALU ops: ALUOp from Func/Op; BSel=1 and ExtSel set per opcode for immediates; then WB.
  - lw/sw: ALUOp=ADD, BSel=1, ExtSel=01; then MEM.
  - beq: ALUOp=SUB; PCWr=Zero, NPCOp=01; then IF.
  - jr: PCWr=1, NPCOp=11; then IF.
- MEM:
  - dmem_req=1 for the whole state; DMWr=1 for sw.
  - On dmem_ack: sw goes to IF; lw goes to WB (DR captures the data on the ack edge).
- WB:
  - RFWr=1.
  - lw: RegSel=00, WDSel=01.
  - I-type ALU ops: RegSel=00, WDSel=00.
  - R-type: RegSel=01, WDSel=00.
  - Then IF.
- Watchdog (IF/MEM):
  - The count starts at 1 in the first req cycle.
  - An ack in any cycle up to and including the TIMEOUT-th cycle is accepted.
  - With no ack by the end of the TIMEOUT-th cycle, go to ERR with err_code 10 (IF) or 11 (MEM).
- ERR: all strobes and requests are 0 and halted=1 until rst.
- Acks outside the matching request state are ignored.
- Counters:
  - cyc_cnt increments every cycle while not halted.
  - instret increments on the final cycle of each instruction.
  - Both wrap modulo 2^CNT_W.

## Timing
- Reset:
  - While rst=1, every strobe and request is 0.
  - Next state is IF; counters, halted and err_code are 0.
  - imem_req rises in the first cycle after rst falls.
- Reset mid-access abandons the request; the memory must tolerate req dropping without an ack.
- All strobes are combinational from state, Op/Func, Zero and ack. State and counters are registered.
- Cycles per instruction with ack in the first request cycle:
  - j, jal: 2.
  - beq, jr: 3.
  - ALU ops, sw: 4.
  - lw: 5.
- Each wait cycle adds 1.
- instret and err_code update on the edge that ends the triggering cycle.

## Structure
- Package mips_mc_pkg holds:
  - Opcode and funct constants.
  - ALUOp, NPCOp, ExtSel, RegSel and WDSel encodings.
  - State enum.
  - err_code values.
- Sub-module mc_wdog (TO_W-bit wait counter with clear, enable and expire) is instantiated once and shared by IF and MEM.

## Test plan
- Reset, then imem_ack tied high, program "addu" → IF-DE-EX-WB, RFWr=1 with RegSel=01 in cycle 4, instret=1 after 4 cycles.
- lw with dmem_ack delayed 3 cycles → dmem_req held 4 cycles, WB strobes WDSel=01, total 8 cycles.
- beq with Zero=1 then Zero=0 → PCWr=1, NPCOp=01 in EX only when Zero=1; both take 3 cycles.
- TIMEOUT=4, imem_ack never asserted → ERR after exactly 4 IF cycles, err_code=10, halted=1, cyc_cnt frozen at 4. Repeat with ack on cycle 4 → accepted, no error.
- Op=6'h3F → ERR from DE, err_code=01. Then rst pulse → state IF, err_code=00, counters 0.
- rst asserted during MEM wait of sw → DMWr and dmem_req 0 while rst=1, imem_req=1 the next cycle, no RFWr/PCWr glitch.
